id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the RV32I core; sits directly upstream of the `alu` and is its only source of operands and opcode. Each accepted instruction is decoded into the 4-bit `alu_op` encoding that `alu` consumes. The block selects the second operand (register or sign-extended immediate) and holds the result in a one-entry register with a valid/ready handshake, flush and illegal-instruction marking.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  32  instruction address
- in_rs1_data  in  32  register-file read port 1
- in_rs2_data  in  32  register-file read port 2
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  registered instruction present
- out_ready  in  1  execute consumes this cycle
- out_r1, out_r2  out  32  ALU operands
- out_alu_op  out  4  ALU opcode
- out_rd  out  5  destination register
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal  out  1  control flags
- out_store_data  out  32  rs2 value for SW
- out_pc, out_br_target  out  32  PC and pc + B-immediate

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLTU 0111 (unsigned compare), NOR 1100, ILLEGAL 1111. The ALU returns 0 for 1111.
- R-type (0110011):
  - ADD (f3 000, f7 0000000) -> 0010; SUB (f3 000, f7 0100000) -> 0110.
  - AND 111 -> 0000; OR 110 -> 0001; SLTU 011 -> 0111.
  - Operand: r2 = rs2.
- I-ALU (0010011): ADDI 000, ANDI 111, ORI 110, SLTIU 011, with the same codes. r2 = sext(imm[31:20]).
- LW (0000011, f3 010): ADD, r2 = I-imm, mem_read = 1, reg_write = 1.
- SW (0100011, f3 010): ADD, r2 = S-imm, mem_write = 1, reg_write = 0, store_data = rs2.
- BEQ/BNE (1100011, f3 000/001): SUB, r2 = rs2, branch = 1, branch_ne = f3[0], reg_write = 0. br_target = pc + sext(B-imm). Execute uses the ALU `zero` output.
- Any other encoding, including signed SLT/SLTI and f7 mismatches:
  - alu_op = 1111, illegal = 1.
  - All write/mem/branch flags are 0.
  - The instruction still propagates with out_valid = 1 so downstream trap logic sees it.
- out_r1 = rs1 data for all legal classes.
- reg_write is forced to 0 when rd == 0.

## Timing
- Reset: out_valid = 0 and every registered output = 0.
- in_ready = !out_valid || out_ready (combinational, no bubble).
- Load on (in_valid && in_ready); latency 1 cycle. The output is valid the cycle after acceptance.
- Hold all outputs stable while out_valid && !out_ready.
- If out_valid && out_ready && !in_valid: out_valid drops to 0 next cycle.
- Simultaneous consume and accept: new data loaded, out_valid stays 1.
- flush has priority over everything:
  - Next cycle out_valid = 0 and the incoming instruction is discarded.
  - in_ready is unaffected by flush.
- rst asserted mid-operation overrides flush and load; outputs are zeroed next edge.
- Payload registers may retain stale data while out_valid = 0, except after reset.
- All immediate arithmetic is modulo 2^32; br_target wraps silently.

## Structure
- The shared package `rv_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - ALU codes (ALU_AND … ALU_ILLEGAL);
  - the immediate-extraction functions.
- One combinational sub-module, `alu_ctrl_decode` (instr -> alu_op, flags, imm_sel, illegal). The register/handshake logic stays in `id_ex_stage`.

## Test plan
- ADD x3,x1,x2 with rs1 = 5, rs2 = 7 -> next cycle out_valid = 1, alu_op = 0010, r1 = 5, r2 = 7, rd = 3, reg_write = 1.
- ADDI x1,x0,-1 -> r2 = 0xFFFFFFFF, alu_op = 0010. ADDI to x0 -> reg_write = 0.
- SW at pc 0x100, S-imm = 8, rs2 = 0xDEAD -> alu_op = 0010, r2 = 8, mem_write = 1, store_data = 0xDEAD.
- BNE at pc 0x40, B-imm = −8 -> alu_op = 0110, branch = 1, branch_ne = 1, br_target = 0x38.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs frozen. Release gives one transfer per cycle, no loss or duplication.
- SLT (f3 010) -> illegal = 1, alu_op = 1111. Then flush on the same cycle as a new in_valid -> out_valid = 0 next cycle. Then rst -> all outputs 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the decode/execute boundary: opcodes, ALU codes,
// decoded control bundle, pipeline payload and immediate extraction helpers.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLTU    = 4'b0111,
    ALU_NOR     = 4'b1100,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE = 2'b00,
    IMM_I    = 2'b01,
    IMM_S    = 2'b10
  } imm_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     branch_ne;
    logic     illegal;
    imm_sel_e imm_sel;
  } ctrl_t;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            branch_ne;
    logic            illegal;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] br_target;
  } payload_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [11:0] imm12);
    return {{20{imm12[11]}}, imm12};
  endfunction

  // S and B immediates share the instr[31:25] / instr[11:7] fields, only scrambled differently.
  function automatic logic [XLEN-1:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, hi, lo};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side signals of the ID/EX register; the stage uses
// the slave modport, whoever drives decode and consumes execute uses master.
interface id_ex_stage_if;
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_r1;
  logic [XLEN-1:0] out_r2;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_branch;
  logic            out_branch_ne;
  logic            out_illegal;
  logic [XLEN-1:0] out_store_data;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_br_target;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_r1, out_r2, out_alu_op, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal,
           out_store_data, out_pc, out_br_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    output in_ready, out_valid, out_r1, out_r2, out_alu_op, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_branch, out_branch_ne, out_illegal,
           out_store_data, out_pc, out_br_target
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode into the ALU opcode, control flags and
// operand-2 immediate selection; anything unrecognised becomes an illegal marker.
module alu_ctrl_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [4:0] rd_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.alu_op  = ALU_ILLEGAL;
    ctrl_o.imm_sel = IMM_NONE;
    case (opcode_i)
      OP_R: begin
        case ({funct7_i, funct3_i})
          {F7_BASE, 3'b000}: ctrl_o.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: ctrl_o.alu_op = ALU_SUB;
          {F7_BASE, 3'b111}: ctrl_o.alu_op = ALU_AND;
          {F7_BASE, 3'b110}: ctrl_o.alu_op = ALU_OR;
          {F7_BASE, 3'b011}: ctrl_o.alu_op = ALU_SLTU;
          default:           ctrl_o.alu_op = ALU_ILLEGAL;
        endcase
        ctrl_o.reg_write = 1'b1;
      end
      OP_I: begin
        case (funct3_i)
          3'b000:  ctrl_o.alu_op = ALU_ADD;
          3'b111:  ctrl_o.alu_op = ALU_AND;
          3'b110:  ctrl_o.alu_op = ALU_OR;
          3'b011:  ctrl_o.alu_op = ALU_SLTU;
          default: ctrl_o.alu_op = ALU_ILLEGAL;
        endcase
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_sel   = IMM_I;
      end
      OP_LOAD: begin
        if (funct3_i == F3_WORD) begin
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.imm_sel   = IMM_I;
        end
      end
      OP_STORE: begin
        if (funct3_i == F3_WORD) begin
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.imm_sel   = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (funct3_i[2:1] == 2'b00) begin
          ctrl_o.alu_op    = ALU_SUB;
          ctrl_o.branch    = 1'b1;
          ctrl_o.branch_ne = funct3_i[0];
        end
      end
      default: ctrl_o.alu_op = ALU_ILLEGAL;
    endcase

    // Illegal encodings must not leave any side-effect flag behind for execute.
    if (ctrl_o.alu_op == ALU_ILLEGAL) begin
      ctrl_o         = '0;
      ctrl_o.alu_op  = ALU_ILLEGAL;
      ctrl_o.imm_sel = IMM_NONE;
      ctrl_o.illegal = 1'b1;
    end
    ctrl_o.reg_write = ctrl_o.reg_write && (rd_i != 5'd0);
  end

endmodule

// File: rtl/id_ex_stage.sv
// One-entry ID/EX pipeline register: decodes the offered instruction, picks
// operand 2 and holds the result behind a valid/ready handshake with flush.
module id_ex_stage
  import rv_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ctrl_t    ctrl;
  payload_t pay_d, pay_q;
  logic     valid_d, valid_q;
  logic     load;
  logic     unused_rs1_field;

  alu_ctrl_decode u_decode (
    .opcode_i (bus.in_instr[6:0]),
    .funct3_i (bus.in_instr[14:12]),
    .funct7_i (bus.in_instr[31:25]),
    .rd_i     (bus.in_instr[11:7]),
    .ctrl_o   (ctrl)
  );

  // rs1 arrives pre-read from the register file, so its field is not needed here.
  assign unused_rs1_field = ^bus.in_instr[19:15];

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    pay_d            = '0;
    pay_d.alu_op     = ctrl.alu_op;
    pay_d.r1         = bus.in_rs1_data;
    pay_d.rd         = bus.in_instr[11:7];
    pay_d.reg_write  = ctrl.reg_write;
    pay_d.mem_read   = ctrl.mem_read;
    pay_d.mem_write  = ctrl.mem_write;
    pay_d.branch     = ctrl.branch;
    pay_d.branch_ne  = ctrl.branch_ne;
    pay_d.illegal    = ctrl.illegal;
    pay_d.store_data = bus.in_rs2_data;
    pay_d.pc         = bus.in_pc;
    pay_d.br_target  = bus.in_pc + imm_b(bus.in_instr[31:25], bus.in_instr[11:7]);
    case (ctrl.imm_sel)
      IMM_I:   pay_d.r2 = imm_i(bus.in_instr[31:20]);
      IMM_S:   pay_d.r2 = imm_s(bus.in_instr[31:25], bus.in_instr[11:7]);
      default: pay_d.r2 = bus.in_rs2_data;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Payload only moves on a real load, which is what keeps outputs frozen under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (load && !bus.flush) begin
        pay_q <= pay_d;
      end
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alu_op     = pay_q.alu_op;
  assign bus.out_r1         = pay_q.r1;
  assign bus.out_r2         = pay_q.r2;
  assign bus.out_rd         = pay_q.rd;
  assign bus.out_reg_write  = pay_q.reg_write;
  assign bus.out_mem_read   = pay_q.mem_read;
  assign bus.out_mem_write  = pay_q.mem_write;
  assign bus.out_branch     = pay_q.branch;
  assign bus.out_branch_ne  = pay_q.branch_ne;
  assign bus.out_illegal    = pay_q.illegal;
  assign bus.out_store_data = pay_q.store_data;
  assign bus.out_pc         = pay_q.pc;
  assign bus.out_br_target  = pay_q.br_target;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected payloads are queued on acceptance
// and compared (through a care mask) when the stage presents them.
module tb_id_ex_stage;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
    logic [31:0] store_data;
    logic [31:0] pc;
    logic [31:0] br_target;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    obs_t        e;
    obs_t        m;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t expQ[$];
  obs_t maskQ[$];

  function automatic obs_t sample();
    return {bus.out_alu_op, bus.out_r1, bus.out_r2, bus.out_rd, bus.out_reg_write,
            bus.out_mem_read, bus.out_mem_write, bus.out_branch, bus.out_branch_ne,
            bus.out_illegal, bus.out_store_data, bus.out_pc, bus.out_br_target};
  endfunction

  // Flags packed as {reg_write, mem_read, mem_write, branch, branch_ne, illegal}.
  function automatic obs_t ex(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [4:0] rd, input logic [5:0] flags,
                              input logic [31:0] sd, input logic [31:0] pc, input logic [31:0] tgt);
    return {op, r1, r2, rd, flags, sd, pc, tgt};
  endfunction

  function automatic obs_t care(input bit rdC, input bit sdC, input bit tgtC, input bit opsC);
    obs_t m;
    m = '1;
    if (!rdC)  m.rd = '0;
    if (!sdC)  m.store_data = '0;
    if (!tgtC) m.br_target = '0;
    if (!opsC) begin
      m.r1 = '0;
      m.r2 = '0;
    end
    return m;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid: got %b, want 0", bus.out_valid);
    end
    vectors++;
    if (sample() !== zero) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, want %h", sample(), zero);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", bus.in_ready);
    end
  endtask

  task automatic test_alu_ops();
    vec_t tbl[$];
    obs_t a, e, m;
    tbl.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h10, 32'd5, 32'd7,
                    ex(4'b0010, 32'd5, 32'd7, 5'd3, 6'b100000, 0, 32'h10, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h14, 32'd0, 32'h99,
                    ex(4'b0010, 32'd0, 32'hFFFF_FFFF, 5'd1, 6'b100000, 0, 32'h14, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_i(12'h005, 5'd1, 3'b000, 5'd0, 7'b0010011), 32'h18, 32'h11, 32'h22,
                    ex(4'b0010, 32'h11, 32'd5, 5'd0, 6'b000000, 0, 32'h18, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd4), 32'h200, 32'h11, 32'h22,
                    ex(4'b0110, 32'h11, 32'h22, 5'd4, 6'b100000, 0, 32'h200, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_r(7'h00, 5'd6, 5'd5, 3'b111, 5'd7), 32'h204, 32'h11, 32'h22,
                    ex(4'b0000, 32'h11, 32'h22, 5'd7, 6'b100000, 0, 32'h204, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_r(7'h00, 5'd6, 5'd5, 3'b110, 5'd8), 32'h208, 32'h11, 32'h22,
                    ex(4'b0001, 32'h11, 32'h22, 5'd8, 6'b100000, 0, 32'h208, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_r(7'h00, 5'd6, 5'd5, 3'b011, 5'd9), 32'h20C, 32'h11, 32'h22,
                    ex(4'b0111, 32'h11, 32'h22, 5'd9, 6'b100000, 0, 32'h20C, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_i(12'h0F0, 5'd5, 3'b111, 5'd10, 7'b0010011), 32'h210, 32'h11, 32'h22,
                    ex(4'b0000, 32'h11, 32'h0F0, 5'd10, 6'b100000, 0, 32'h210, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_i(12'h800, 5'd5, 3'b110, 5'd11, 7'b0010011), 32'h214, 32'h11, 32'h22,
                    ex(4'b0001, 32'h11, 32'hFFFF_F800, 5'd11, 6'b100000, 0, 32'h214, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_i(12'h001, 5'd5, 3'b011, 5'd12, 7'b0010011), 32'h218, 32'h11, 32'h22,
                    ex(4'b0111, 32'h11, 32'd1, 5'd12, 6'b100000, 0, 32'h218, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_r(7'h01, 5'd6, 5'd5, 3'b000, 5'd13), 32'h21C, 32'h11, 32'h22,
                    ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h21C, 0), care(0, 0, 0, 0)});
    tbl.push_back('{enc_i(12'h004, 5'd5, 3'b010, 5'd14, 7'b0010011), 32'h220, 32'h11, 32'h22,
                    ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h220, 0), care(0, 0, 0, 0)});
    tbl.push_back('{enc_r(7'h00, 5'd6, 5'd5, 3'b101, 5'd15), 32'h224, 32'h11, 32'h22,
                    ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h224, 0), care(0, 0, 0, 0)});
    tbl.push_back('{32'h0001_20B7, 32'h228, 32'h11, 32'h22,
                    ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h228, 0), care(0, 0, 0, 0)});
    bus.out_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      expQ.push_back(tbl[i].e);
      maskQ.push_back(tbl[i].m);
      offer(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL alu_valid[%0d]: got %b, want 1", i, bus.out_valid);
      end
      a = sample();
      e = expQ.pop_front();
      m = maskQ.pop_front();
      vectors++;
      if ((a & m) !== (e & m)) begin
        miscompares++;
        $display("[TB] FAIL alu_ops[%0d]: got %h, want %h (mask %h)", i, a, e, m);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_valid: got %b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_mem_branch();
    vec_t tbl[$];
    obs_t a, e, m;
    tbl.push_back('{enc_i(12'h010, 5'd1, 3'b010, 5'd9, 7'b0000011), 32'h80, 32'h1000, 32'h5,
                    ex(4'b0010, 32'h1000, 32'h10, 5'd9, 6'b110000, 0, 32'h80, 0), care(1, 0, 0, 1)});
    tbl.push_back('{enc_s(12'h008, 5'd2, 5'd1), 32'h100, 32'h2000, 32'hDEAD,
                    ex(4'b0010, 32'h2000, 32'd8, 0, 6'b001000, 32'hDEAD, 32'h100, 0), care(0, 1, 0, 1)});
    tbl.push_back('{enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001), 32'h40, 32'd3, 32'd4,
                    ex(4'b0110, 32'd3, 32'd4, 0, 6'b000110, 0, 32'h40, 32'h38), care(0, 0, 1, 1)});
    tbl.push_back('{enc_b(13'h0020, 5'd2, 5'd1, 3'b000), 32'hFFFF_FFF0, 32'd9, 32'd9,
                    ex(4'b0110, 32'd9, 32'd9, 0, 6'b000100, 0, 32'hFFFF_FFF0, 32'h10), care(0, 0, 1, 1)});
    tbl.push_back('{enc_i(12'h010, 5'd1, 3'b000, 5'd9, 7'b0000011), 32'h84, 32'h1000, 32'h5,
                    ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h84, 0), care(0, 0, 0, 0)});
    bus.out_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      expQ.push_back(tbl[i].e);
      maskQ.push_back(tbl[i].m);
      offer(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL memb_valid[%0d]: got %b, want 1", i, bus.out_valid);
      end
      a = sample();
      e = expQ.pop_front();
      m = maskQ.pop_front();
      vectors++;
      if ((a & m) !== (e & m)) begin
        miscompares++;
        $display("[TB] FAIL mem_branch[%0d]: got %h, want %h (mask %h)", i, a, e, m);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    bit   acc, xfer;
    obs_t snap, a, e, m;
    @(posedge clk);
    #1;
    while ((sent < N || got < N) && cyc < 60) begin
      bus.in_valid = (sent < N);
      bus.in_instr = enc_r((sent % 2 == 0) ? 7'h00 : 7'h20, 5'd2, 5'd1, 3'b000, 5'(sent + 1));
      bus.in_pc = 32'h400 + 32'(4 * sent);
      bus.in_rs1_data = 32'(100 + sent);
      bus.in_rs2_data = 32'(200 + sent);
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        vectors++;
        if (bus.in_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bp_in_ready cyc %0d: got %b, want 0", cyc, bus.in_ready);
        end
        if (cyc == 2) begin
          snap = sample();
        end else begin
          vectors++;
          if (bus.out_valid !== 1'b1 || sample() !== snap) begin
            miscompares++;
            $display("[TB] FAIL bp_hold cyc %0d: got %b/%h, want 1/%h", cyc, bus.out_valid, sample(), snap);
          end
        end
      end
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (acc) begin
        expQ.push_back(ex((sent % 2 == 0) ? 4'b0010 : 4'b0110, 32'(100 + sent), 32'(200 + sent),
                          5'(sent + 1), 6'b100000, 0, 32'h400 + 32'(4 * sent), 0));
        maskQ.push_back(care(1, 0, 0, 1));
      end
      if (xfer) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL bp_extra cyc %0d: got transfer %h, want none", cyc, sample());
        end else begin
          a = sample();
          e = expQ.pop_front();
          m = maskQ.pop_front();
          if ((a & m) !== (e & m)) begin
            miscompares++;
            $display("[TB] FAIL bp_data[%0d]: got %h, want %h", got, a, e);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (cyc >= 60) begin
      miscompares++;
      $display("[TB] FAIL bp_timeout: got %0d of %0d transfers in %0d cycles", got, N, cyc);
    end
    vectors++;
    if (got != N || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d transfers (%0d pending), want %0d (0)", got, expQ.size(), N);
    end
    expQ.delete();
    maskQ.delete();
  endtask

  task automatic test_illegal_flush();
    obs_t a, e, m;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    expQ.push_back(ex(4'b1111, 0, 0, 0, 6'b000001, 0, 32'h300, 0));
    maskQ.push_back(care(0, 0, 0, 0));
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'h300, 32'h1, 32'h2);
    @(negedge clk);
    a = sample();
    e = expQ.pop_front();
    m = maskQ.pop_front();
    vectors++;
    if (bus.out_valid !== 1'b1 || (a & m) !== (e & m)) begin
      miscompares++;
      $display("[TB] FAIL slt_illegal: got %b/%h, want 1/%h", bus.out_valid, a, e);
    end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_in_ready_stalled: got %b, want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_held: got out_valid %b, want 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5), 32'h304, 32'h1, 32'h2);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL preflush_load: got %b/rd %0d, want 1/rd 5", bus.out_valid, bus.out_rd);
    end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd6);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_in_ready: got %b, want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_incoming: got out_valid %b, want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    obs_t zero;
    zero = '0;
    bus.out_ready = 1'b0;
    offer(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd7), 32'h500, 32'h33, 32'h44);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_r1 !== 32'h33) begin
      miscompares++;
      $display("[TB] FAIL premid_load: got %b/r1 %h, want 1/r1 00000033", bus.out_valid, bus.out_r1);
    end
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd8);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || sample() !== zero) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %b/%h, want 0/%h", bus.out_valid, sample(), zero);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_alu_ops();
    test_mem_branch();
    test_back_to_back();
    test_illegal_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
